// File: rtl/mul_arb_sched.sv
// mul_arb_sched: round-robin arbiter that shares one fp16 x int4 multiplier
// among NREQ requesters, with one operation in flight at a time.
// Optional WAIT-state watchdog compiled in with `define MUL_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mul_arb_sched #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned ACT_WIDTH      = 16,
  parameter int unsigned W_WIDTH        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*ACT_WIDTH-1:0]   act_in,
  input  logic [NREQ*W_WIDTH-1:0]     w_in,
  output logic [NREQ-1:0]             grant,
  output logic                        mul_start,
  output logic [ACT_WIDTH-1:0]        mul_act,
  output logic [W_WIDTH-1:0]          mul_weight,
  input  logic                        mul_busy,
  input  logic                        mul_done,
  input  logic                        mul_sign,
  input  logic [4:0]                  mul_exp,
  input  logic [13:0]                 mul_mant,
  output logic                        out_valid,
  output logic [$clog2(NREQ)-1:0]     out_id,
  output logic                        out_sign,
  output logic [4:0]                  out_exp,
  output logic [13:0]                 out_mant,
  output logic                        err
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned IDX_W = ID_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Reject configurations outside the supported range at elaboration.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("mul_arb_sched: unsupported parameter value");
  end

  state_t                state, state_d;
  logic [ID_W-1:0]       rr_ptr, rr_d;
  logic [ID_W-1:0]       cur_id, cur_id_d;
  logic [NREQ-1:0]       grant_d;
  logic                  start_d;
  logic [ACT_WIDTH-1:0]  act_d;
  logic [W_WIDTH-1:0]    wgt_d;
  logic                  ov_d;
  logic [ID_W-1:0]       oid_d;
  logic                  osign_d;
  logic [4:0]            oexp_d;
  logic [13:0]           omant_d;
  logic                  err_d;

  logic                  sel_found;
  logic [ID_W-1:0]       sel_id;
  logic [IDX_W-1:0]      idx;
  logic [ID_W-1:0]       cand;

  logic [ACT_WIDTH-1:0]  act_arr [NREQ];
  logic [W_WIDTH-1:0]    w_arr   [NREQ];

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      wd_cnt, wd_cnt_d;
`endif

  // Split the flat operand buses into per-requester lanes.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign act_arr[g] = act_in[g*ACT_WIDTH +: ACT_WIDTH];
    assign w_arr[g]   = w_in[g*W_WIDTH +: W_WIDTH];
  end

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NREQ - 1)) return '0;
    return id + ID_W'(1);
  endfunction

  // Round-robin pick: first pending request at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    cand      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = IDX_W'(rr_ptr) + IDX_W'(i);
      if (idx >= IDX_W'(NREQ)) idx = idx - IDX_W'(NREQ);
      cand = idx[ID_W-1:0];
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_d  = state;
    rr_d     = rr_ptr;
    cur_id_d = cur_id;
    grant_d  = '0;
    start_d  = 1'b0;
    act_d    = mul_act;
    wgt_d    = mul_weight;
    ov_d     = 1'b0;
    oid_d    = out_id;
    osign_d  = out_sign;
    oexp_d   = out_exp;
    omant_d  = out_mant;
    err_d    = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    wd_cnt_d = '0;
`endif
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_d  = NREQ'(1) << sel_id;
          act_d    = act_arr[sel_id];
          wgt_d    = w_arr[sel_id];
          cur_id_d = sel_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!mul_busy) begin
          start_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mul_done) begin
          ov_d    = 1'b1;
          oid_d   = cur_id;
          osign_d = mul_sign;
          oexp_d  = mul_exp;
          omant_d = mul_mant;
          state_d = DONE;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rr_d    = next_id(cur_id);
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        rr_d    = next_id(cur_id);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      grant      <= '0;
      mul_start  <= 1'b0;
      mul_act    <= '0;
      mul_weight <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_mant   <= '0;
      err        <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_d;
      cur_id     <= cur_id_d;
      grant      <= grant_d;
      mul_start  <= start_d;
      mul_act    <= act_d;
      mul_weight <= wgt_d;
      out_valid  <= ov_d;
      out_id     <= oid_d;
      out_sign   <= osign_d;
      out_exp    <= oexp_d;
      out_mant   <= omant_d;
      err        <= err_d;
`ifdef MUL_ARB_TIMEOUT_EN
      wd_cnt     <= wd_cnt_d;
`endif
    end
  end

endmodule

// File: doc/mul_arb_sched.md
MUL_ARB_SCHED -- requirements
Module: mul_arb_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one fp16 x int4 multiplier (2..8).
REQ-002 SHALL have parameter ACT_WIDTH, default 16, activation width (fp16: 1 sign, 5 exp, 10 mantissa).
REQ-003 SHALL have parameter W_WIDTH, default 4, signed weight width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15, watchdog limit, used only when the watchdog is compiled in.
REQ-005 SHALL have ports: clk input 1, clock; rst input 1, reset (asynchronous, active-low).
REQ-006 SHALL have port req input NREQ, per-requester operation request, held until granted.
REQ-007 SHALL have port act_in input NREQ*ACT_WIDTH, activation of requester i at bits [i*ACT_WIDTH +: ACT_WIDTH].
REQ-008 SHALL have port w_in input NREQ*W_WIDTH, weight of requester i at bits [i*W_WIDTH +: W_WIDTH].
REQ-009 SHALL have port grant output NREQ, one-hot one-cycle pulse meaning the requester's operands are captured.
REQ-010 SHALL have ports mul_start output 1, mul_act output ACT_WIDTH, mul_weight output W_WIDTH, all driving the multiplier.
REQ-011 SHALL have ports mul_busy input 1 and mul_done input 1 (multiplier completion pulse).
REQ-012 SHALL have ports mul_sign input 1, mul_exp input 5, mul_mant input 14, the multiplier result.
REQ-013 SHALL have ports out_valid output 1, out_id output clog2(NREQ), out_sign output 1, out_exp output 5, out_mant output 14.
REQ-014 SHALL have port err output 1, watchdog-expiry pulse, tied 0 when the watchdog is compiled out.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; exactly one operation in flight.
REQ-016 SHALL, in IDLE with any req bit high, select the first set bit at or after rr_ptr (wrapping modulo NREQ), register its act/w into mul_act/mul_weight, pulse grant for that bit, and go to ISSUE next cycle.
REQ-017 SHALL, in ISSUE, assert mul_start for exactly one cycle if mul_busy is 0, then go to WAIT; if mul_busy is 1, stay in ISSUE with mul_start low.
REQ-018 SHALL, in WAIT, on mul_done=1 register mul_sign/mul_exp/mul_mant and go to DONE; mul_done in IDLE, ISSUE or DONE SHALL be ignored.
REQ-019 SHALL, in DONE, assert out_valid for one cycle with out_id equal to the granted index, set rr_ptr to (granted index + 1) mod NREQ, and return to IDLE.
REQ-020 SHALL hold out_sign/out_exp/out_mant/out_id stable from DONE until the next DONE.
REQ-021 SHALL hold mul_act/mul_weight constant from grant until leaving WAIT.
REQ-022 SHALL give minimum request-to-out_valid latency of 4 cycles plus multiplier latency (grant cycle, ISSUE, done capture, DONE).
REQ-023 SHALL ignore req changes outside IDLE; a non-granted req stays pending, with no starvation (each pending requester is granted within NREQ operations).

Reset
REQ-024 SHALL, on rst low (any state, including mid-operation), go to IDLE immediately, set rr_ptr=0 and drive grant, mul_start, mul_act, mul_weight, out_valid, out_id, out_sign, out_exp, out_mant, err to 0.
REQ-025 SHALL discard an in-flight operation on reset and produce no out_valid for it.

Configuration
REQ-026 SHALL, with macro MUL_ARB_TIMEOUT_EN defined, count WAIT cycles and, when the count reaches TIMEOUT_CYCLES without mul_done, pulse err for one cycle, assert no out_valid, advance rr_ptr past the granted index and return to IDLE.
REQ-027 SHALL, without MUL_ARB_TIMEOUT_EN, contain no counter, tie err to 0, and wait in WAIT indefinitely.

Verification
REQ-028 SHALL cover: req=0001, act_in[0]=16'h3C00, w_in[0]=4'h3, mul_done 4 cycles after mul_start -> grant=0001, one mul_start, out_valid with out_id=0 and captured result.
REQ-029 SHALL cover: req=1111 held for 4 operations from reset -> grant order 0001, 0010, 0100, 1000.
REQ-030 SHALL cover: mul_busy=1 for 3 cycles during ISSUE -> mul_start delayed until mul_busy=0, asserted exactly once.
REQ-031 SHALL cover: rst low in WAIT, then mul_done pulse after release -> no out_valid, rr_ptr=0, all outputs 0.
REQ-032 SHALL cover: with MUL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15, no mul_done -> err pulses 15 cycles after WAIT entry and FSM returns to IDLE; without the macro, err stays 0.
REQ-033 SHALL cover: spurious mul_done in IDLE -> out_valid stays 0.
